// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: bubble encoding, default reset PC and the
// fetch-state encoding used by the instruction fetch stage.
package pipeline_pkg;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_REQ  = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_DROP = 2'd2
  } fetch_state_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-entry {pc, instr} holding buffer for a fetch response that arrives
// while IF/ID is stalled.
module if_skid_buf
  import pipeline_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        unload,
  input  logic        clear,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_instr,
  output logic        full,
  output logic [31:0] buf_pc,
  output logic [31:0] buf_instr
);

  // Load wins over unload so a same-edge refill is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full      <= 1'b0;
      buf_pc    <= '0;
      buf_instr <= NOP_INSTR_DEFAULT;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      full      <= 1'b1;
      buf_pc    <= load_pc;
      buf_instr <= load_instr;
    end else if (unload) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, single-outstanding fetch FSM and the
// IF/ID pipeline register, with flush redirect and hazard-unit stalls.
//
//   state      | meaning
//   FETCH_REQ  | may issue a fetch request for pc
//   FETCH_WAIT | one request outstanding, waiting for its response
//   FETCH_DROP | outstanding request is stale, its response is discarded
module if_stage
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_write,
  input  logic        if_id_write,
  input  logic        flush,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  req_pc;
  logic         buf_full;
  logic [31:0]  buf_pc;
  logic [31:0]  buf_instr;
  logic         accept;
  logic         rsp;
  logic         buf_load;
  logic         buf_unload;

  assign imem_req   = rst_n && (state == FETCH_REQ) && pc_write && !buf_full && !flush;
  assign imem_addr  = pc;
  assign accept     = imem_req && imem_ready;
  assign rsp        = imem_rvalid && (state == FETCH_WAIT);
  assign buf_load   = rsp && !flush && (!if_id_write || buf_full);
  assign buf_unload = if_id_write && buf_full && !flush;

  if_skid_buf u_skid_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (buf_load),
    .unload     (buf_unload),
    .clear      (flush),
    .load_pc    (req_pc),
    .load_instr (imem_rdata),
    .full       (buf_full),
    .buf_pc     (buf_pc),
    .buf_instr  (buf_instr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH_REQ;
      pc          <= RESET_PC;
      req_pc      <= '0;
      if_id_pc    <= '0;
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
    end else if (flush) begin
      pc          <= word_align(branch_target);
      if_id_pc    <= '0;
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
      // Any request still in flight belongs to the wrong path.
      case (state)
        FETCH_REQ:  state <= accept ? FETCH_DROP : FETCH_REQ;
        FETCH_WAIT: state <= imem_rvalid ? FETCH_REQ : FETCH_DROP;
        FETCH_DROP: state <= imem_rvalid ? FETCH_REQ : FETCH_DROP;
        default:    state <= FETCH_REQ;
      endcase
    end else begin
      case (state)
        FETCH_REQ: begin
          if (accept) begin
            req_pc <= pc;
            pc     <= pc + 32'd4;
            state  <= FETCH_WAIT;
          end
        end
        FETCH_WAIT: if (imem_rvalid) state <= FETCH_REQ;
        FETCH_DROP: if (imem_rvalid) state <= FETCH_REQ;
        default:    state <= FETCH_REQ;
      endcase
      if (if_id_write) begin
        if (buf_full) begin
          if_id_pc    <= buf_pc;
          if_id_instr <= buf_instr;
          if_id_valid <= 1'b1;
        end else if (rsp) begin
          if_id_pc    <= req_pc;
          if_id_instr <= imem_rdata;
          if_id_valid <= 1'b1;
        end else begin
          if_id_pc    <= pc;
          if_id_instr <= NOP_INSTR;
          if_id_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), bubble encoding in IF/ID.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  reset; one clock, reset is asynchronous and active-low.
REQ-005 pc_write  input  1  from hazard unit; 0 blocks issuing a new fetch request.
REQ-006 if_id_write  input  1  from hazard unit; 0 holds IF/ID register contents.
REQ-007 flush  input  1  taken branch/jump resolved in EX.
REQ-008 branch_target  input  32  redirect address; bits [1:0] ignored and forced to 0.
REQ-009 imem_req  output  1  fetch request valid.
REQ-010 imem_addr  output  32  fetch address, equals PC register.
REQ-011 imem_ready  input  1  memory accepts request this cycle when imem_req=1.
REQ-012 imem_rvalid  input  1  instruction data valid; at most one response per accepted request, any latency >=1 cycle.
REQ-013 imem_rdata  input  32  instruction word.
REQ-014 if_id_pc / if_id_instr / if_id_valid  output  32/32/1  IF/ID pipeline register to decode and hazard unit.

Function
REQ-015 FSM states: REQ (issuing), WAIT (one request outstanding), DROP (outstanding request is stale, response to be discarded); at most one outstanding request.
REQ-016 imem_req = 1 only in REQ with pc_write=1, buffer empty and flush=0; combinational from state and these inputs.
REQ-017 REQ and imem_req and imem_ready: latch req_pc<=pc, pc<=pc+4 (mod 2^32 wrap), go WAIT.
REQ-018 WAIT and imem_rvalid, flush=0: if if_id_write=1 and buffer empty, IF/ID<={req_pc, imem_rdata, 1}; otherwise response stored in one-entry buffer; go REQ.
REQ-019 if_id_write=1, buffer full: IF/ID loads from buffer, buffer empties in same edge.
REQ-020 if_id_write=1, no response and buffer empty: IF/ID<={pc_unchanged_value, NOP_INSTR, 0} (bubble).
REQ-021 if_id_write=0 and flush=0: IF/ID holds all three fields.
REQ-022 flush has highest priority: pc<=branch_target, IF/ID<={0, NOP_INSTR, 0}, buffer cleared, regardless of if_id_write or pc_write.
REQ-023 flush in WAIT with no rvalid, or in REQ with request accepted same cycle: go DROP; flush in WAIT with rvalid same cycle: response discarded, go REQ.
REQ-024 DROP: no request issued; imem_rvalid discarded, go REQ; further flush in DROP only updates pc.
REQ-025 Minimum latency: request accepted cycle N, rvalid cycle N+1, if_id_valid=1 after edge ending N+1; peak throughput one instruction per 2 cycles.

Reset
REQ-026 rst_n=0 asynchronously forces pc=RESET_PC, state=REQ, buffer empty, if_id_pc=0, if_id_instr=NOP_INSTR, if_id_valid=0; imem_req is 0 while rst_n=0.
REQ-027 Reset asserted with request outstanding: the late response after release is not tracked; memory is reset concurrently by system requirement.

Structure
REQ-028 Shared package pipeline_pkg holds NOP_INSTR, RESET_PC default, fetch-state enum (REQ/WAIT/DROP).
REQ-029 One sub-module if_skid_buf: one-entry {pc, instr} holding buffer with load/unload/clear and full flag.

Verification
REQ-030 Reset release, ready=1, rvalid next cycle, rdata=32'h00500093: imem_addr 0,4,8 on successive requests; IF/ID gets pc=0 valid=1 instr=32'h00500093.
REQ-031 if_id_write=0 and pc_write=0 for 3 cycles while response for pc=8 arrives: IF/ID holds pc=4 entry, buffer takes pc=8, no request; release -> IF/ID pc=8 next edge.
REQ-032 flush with branch_target=32'h0000_0103 while WAIT: next request addr 32'h0000_0100, late stale response dropped, IF/ID valid=0 instr=NOP_INSTR.
REQ-033 flush and if_id_write=0 same cycle: IF/ID cleared to bubble, buffer empty.
REQ-034 pc=32'hFFFF_FFFC accepted: next imem_addr 32'h0000_0000.
REQ-035 rst_n asserted mid-WAIT, asynchronous: outputs reach reset values before next clk edge.
